// File: rtl/bin2seg_display_pkg.sv
// Shared types and constants for the binary-to-seven-segment display path:
// conversion FSM states, digit geometry and active-low segment patterns.
package bin2seg_display_pkg;

   localparam int unsigned NDIGITS = 3;
   localparam int unsigned ITER    = 7;
   localparam int unsigned BIN_W   = 7;
   localparam int unsigned BCD_W   = 4 * NDIGITS;
   localparam int unsigned SEG_W   = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_e;

   localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
   localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
   localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
   localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
   localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
   localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
   localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
   localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
   localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
   localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

   // BCD digit to active-low segments, dp off; non-decimal nibbles go dark.
   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2seg_display_if.sv
// Bus between the upstream converter/board and the display block.
// master drives the binary value; slave returns digits, busy and the display pins.
interface bin2seg_display_if;
   import bin2seg_display_pkg::*;

   logic [BIN_W-1:0] bin;
   logic [BCD_W-1:0] bcd;
   logic             busy;
   logic [SEG_W-1:0] seg;
   logic [2:0]       an;

   modport master (output bin, input bcd, input busy, input seg, input an);
   modport slave  (input bin, output bcd, output busy, output seg, output an);

endinterface

// File: rtl/bin2seg_display_seg7_scan.sv
// Multiplexed 3-digit seven-segment scanner with leading-zero blanking.
// seg/an are registered from the current digit index every clock.
module seg7_scan
   import bin2seg_display_pkg::*;
#(
   parameter int unsigned REFRESH_CNT = 12000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BCD_W-1:0] bcd_i,
   output logic [SEG_W-1:0] seg_o,
   output logic [2:0]       an_o
);

   localparam int unsigned CW = $clog2(REFRESH_CNT);

   logic [CW-1:0]    cnt_q;
   logic [1:0]       idx_q;
   logic [SEG_W-1:0] seg_q;
   logic [2:0]       an_q;

   logic [3:0]       nib_c;
   logic             blank_c;
   logic [2:0]       an_c;
   logic [SEG_W-1:0] seg_c;

   // Digit select; tens blank only when hundreds is also zero.
   always_comb begin
      nib_c   = 4'd0;
      blank_c = 1'b1;
      an_c    = 3'b111;
      case (idx_q)
         2'd0: begin
            nib_c   = bcd_i[3:0];
            blank_c = 1'b0;
            an_c    = 3'b110;
         end
         2'd1: begin
            nib_c   = bcd_i[7:4];
            blank_c = (bcd_i[11:8] == 4'd0) && (bcd_i[7:4] == 4'd0);
            an_c    = 3'b101;
         end
         2'd2: begin
            nib_c   = bcd_i[11:8];
            blank_c = (bcd_i[11:8] == 4'd0);
            an_c    = 3'b011;
         end
         default: begin
            nib_c   = 4'd0;
            blank_c = 1'b1;
            an_c    = 3'b111;
         end
      endcase
      seg_c = blank_c ? SEG_BLANK : seg_decode(nib_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= 2'd0;
         seg_q <= SEG_BLANK;
         an_q  <= 3'b111;
      end else begin
         seg_q <= seg_c;
         an_q  <= an_c;
         if (cnt_q == CW'(REFRESH_CNT - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;

endmodule

// File: rtl/bin2seg_display.sv
// 7-bit binary to 3-digit BCD via sequential double-dabble, restarted on any
// input change, feeding a multiplexed seven-segment scanner.
module bin2seg_display
   import bin2seg_display_pkg::*;
#(
   parameter int unsigned NBITS       = 7,
   parameter int unsigned REFRESH_CNT = 12000
) (
   input  logic             clk,
   input  logic             rst_n,
   bin2seg_display_if.slave bus
);

   localparam int unsigned WW = BCD_W + NBITS;

   state_e           state_q;
   logic [NBITS-1:0] bin_prev_q;
   logic [WW-1:0]    work_q;
   logic [2:0]       iter_q;
   logic             pending_q;
   logic             busy_q;
   logic [BCD_W-1:0] bcd_q;

   logic             change_c;
   logic [WW-1:0]    adj_c;
   logic [WW-1:0]    work_step_c;

   assign change_c = (bus.bin != bin_prev_q);

   // One double-dabble iteration: add 3 to nibbles >= 5, then shift left.
   always_comb begin
      adj_c = work_q;
      for (int i = 0; i < NDIGITS; i++) begin
         if (adj_c[NBITS + 4*i +: 4] >= 4'd5)
            adj_c[NBITS + 4*i +: 4] = adj_c[NBITS + 4*i +: 4] + 4'd3;
      end
      work_step_c = {adj_c[WW-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bin_prev_q <= '0;
         work_q     <= '0;
         iter_q     <= 3'd0;
         pending_q  <= 1'b0;
         busy_q     <= 1'b0;
         bcd_q      <= '0;
      end else begin
         bin_prev_q <= bus.bin;
         case (state_q)
            IDLE: begin
               if (change_c || pending_q) begin
                  work_q    <= {BCD_W'(0), bus.bin};
                  iter_q    <= 3'd0;
                  pending_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= CONVERT;
               end
            end
            CONVERT: begin
               work_q <= work_step_c;
               iter_q <= iter_q + 3'd1;
               // Changes seen mid-conversion are replayed once back in IDLE.
               if (change_c)
                  pending_q <= 1'b1;
               if (iter_q == 3'(ITER - 1)) begin
                  bcd_q   <= work_step_c[WW-1:NBITS];
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.bcd  = bcd_q;
   assign bus.busy = busy_q;

   seg7_scan #(
      .REFRESH_CNT (REFRESH_CNT)
   ) u_scan (
      .clk   (clk),
      .rst_n (rst_n),
      .bcd_i (bcd_q),
      .seg_o (bus.seg),
      .an_o  (bus.an)
   );

endmodule
